// File: rtl/scope_pkg.sv
// Shared types and time-scale constants for the scope trigger/capture path.
package scope_pkg;

  typedef enum logic [1:0] {
    TRIG_RISE  = 2'b00,
    TRIG_FALL  = 2'b01,
    TRIG_LEVEL = 2'b10,
    TRIG_FORCE = 2'b11
  } trig_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } cap_state_t;

  localparam logic [31:0] DIV_TS0     = 32'd1250000;
  localparam logic [31:0] DIV_TS1     = 32'd125000;
  localparam logic [31:0] DIV_TS2     = 32'd12500;
  localparam logic [31:0] DIV_TS3     = 32'd1250;
  localparam logic [31:0] DIV_TS4     = 32'd125;
  localparam logic [31:0] DIV_TS5     = 32'd16;
  localparam logic [31:0] DIV_DEFAULT = 32'd10;

  // Decimation period for a one-hot time-scale select; anything else is the fast default.
  function automatic logic [31:0] decim_period(input logic [5:0] ts);
    logic [31:0] n;
    case (ts)
      6'b000001: n = DIV_TS0;
      6'b000010: n = DIV_TS1;
      6'b000100: n = DIV_TS2;
      6'b001000: n = DIV_TS3;
      6'b010000: n = DIV_TS4;
      6'b100000: n = DIV_TS5;
      default:   n = DIV_DEFAULT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port frame buffer: synchronous write, registered read with reset.
module capture_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds the last sample between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/scope_capture.sv
// Trigger-and-capture engine: scale, decimate, pre-trigger ring, frame readout.
module scope_capture
  import scope_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned GAIN   = 10,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [5:0]        time_scale,
  input  logic [1:0]        trig_mode,
  input  logic [AW-1:0]     pretrig,
  input  logic              arm,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              triggered,
  output logic              busy
);

  localparam int unsigned PW = DATA_W + 32;

  cap_state_t        state_q, state_d;
  trig_mode_t        mode_q, mode_d;
  logic [31:0]       cnt_q, cnt_d, period_q, period_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     pre_cnt_q, pre_cnt_d, rd_cnt_q, rd_cnt_d, pretrig_q, pretrig_d;
  logic [AW:0]       post_cnt_q, post_cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d, level_q, level_d;
  logic              prev_vld_q, prev_vld_d;
  logic              rd_valid_q, rd_valid_d, full_q, full_d, empty_q, empty_d;
  logic              triggered_q, triggered_d, busy_q, busy_d;

  logic [PW-1:0]     prod;
  logic [DATA_W-1:0] scaled;
  logic [AW:0]       span;
  logic              strobe, hit, ram_we, ram_re;

  assign prod   = PW'(sample_in) * PW'(GAIN);
  assign scaled = (prod > PW'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : prod[DATA_W-1:0];
  assign strobe = (cnt_q == period_q - 32'd1);
  // Post-trigger sample count, including the trigger sample itself.
  assign span   = (AW+1)'(DEPTH) - (AW+1)'(pretrig_q);

  // Edge modes need a previous sample from this capture.
  always_comb begin
    hit = 1'b0;
    case (mode_q)
      TRIG_RISE:  hit = prev_vld_q && (prev_q < level_q) && (scaled >= level_q);
      TRIG_FALL:  hit = prev_vld_q && (prev_q >= level_q) && (scaled < level_q);
      TRIG_LEVEL: hit = (scaled >= level_q);
      default:    hit = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    pretrig_d   = pretrig_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    level_d     = level_q;
    full_d      = full_q;
    empty_d     = empty_q;
    triggered_d = triggered_q;
    rd_valid_d  = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          // pretrig is AW bits wide, so it can never exceed DEPTH-1.
          period_d   = decim_period(time_scale);
          mode_d     = trig_mode_t'(trig_mode);
          pretrig_d  = pretrig;
          level_d    = trig_level;
          cnt_d      = '0;
          wr_ptr_d   = '0;
          pre_cnt_d  = '0;
          post_cnt_d = '0;
          rd_cnt_d   = '0;
          prev_d     = '0;
          prev_vld_d = 1'b0;
          state_d    = (pretrig == '0) ? S_WAIT : S_PRE;
        end
      end
      S_PRE, S_WAIT, S_POST: begin
        cnt_d = strobe ? '0 : cnt_q + 32'd1;
        if (strobe) begin
          ram_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + AW'(1);
          prev_d     = scaled;
          prev_vld_d = 1'b1;
          if (state_q == S_PRE) begin
            pre_cnt_d = pre_cnt_q + AW'(1);
            if (pre_cnt_d == pretrig_q) state_d = S_WAIT;
          end else if (state_q == S_WAIT) begin
            if (hit) begin
              triggered_d = 1'b1;
              post_cnt_d  = (AW+1)'(1);
              rd_ptr_d    = wr_ptr_q - pretrig_q;
              state_d     = (span == (AW+1)'(1)) ? S_DONE : S_POST;
            end
          end else begin
            post_cnt_d = post_cnt_q + (AW+1)'(1);
            if (post_cnt_d == span) state_d = S_DONE;
          end
          if (state_d == S_DONE) begin
            full_d  = 1'b1;
            empty_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (rd_en && !empty_q) begin
          ram_re     = 1'b1;
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + AW'(1);
          rd_cnt_d   = rd_cnt_q + AW'(1);
          if (rd_cnt_q == AW'(DEPTH - 1)) begin
            full_d      = 1'b0;
            empty_d     = 1'b1;
            triggered_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_PRE) || (state_d == S_WAIT) || (state_d == S_POST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mode_q      <= TRIG_RISE;
      cnt_q       <= '0;
      period_q    <= DIV_DEFAULT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      pretrig_q   <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      level_q     <= '0;
      rd_valid_q  <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      triggered_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      pretrig_q   <= pretrig_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      level_q     <= level_d;
      rd_valid_q  <= rd_valid_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      triggered_q <= triggered_d;
      busy_q      <= busy_d;
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (scaled),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign rd_valid  = rd_valid_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign triggered = triggered_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_scope_capture.sv
// Table-driven capture scenarios with a frame scoreboard for scope_capture.
module tb_scope_capture;
  import scope_pkg::*;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned GAIN   = 10;
  localparam int unsigned AW     = 4;
  localparam int unsigned NVEC   = 11;

  typedef enum int {PAT_UP, PAT_DN, PAT_CONST, PAT_NOTCH} pat_t;

  // Inputs of one capture plus the hand-derived strobe index that must trigger.
  typedef struct {
    trig_mode_t  mode;
    int unsigned pre;
    int unsigned level;
    pat_t        pat;
    int unsigned base;
    int unsigned step;
    bit          abuse;
    int unsigned exp_trig;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] sample_in, trig_level, rd_data;
  logic [5:0]        time_scale;
  logic [1:0]        trig_mode;
  logic [AW-1:0]     pretrig;
  logic              arm, rd_en, rd_valid, full, empty, triggered, busy;

  int                n_checks = 0;
  int                n_errors = 0;
  logic [DATA_W-1:0] sb[$];
  vec_t              tbl[NVEC];

  scope_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .GAIN(GAIN)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .trig_level(trig_level),
    .time_scale(time_scale), .trig_mode(trig_mode), .pretrig(pretrig),
    .arm(arm), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .triggered(triggered), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned gen(input vec_t v, input int unsigned k);
    case (v.pat)
      PAT_UP:    return v.base + k * v.step;
      PAT_DN:    return (v.base > k * v.step) ? v.base - k * v.step : 0;
      PAT_CONST: return v.base;
      default:   return (k >= 1 && k <= 5) ? v.step : v.base;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] scale(input int unsigned x);
    longint unsigned p;
    p = longint'(x) * GAIN;
    return (p > 64'd65535) ? 16'hFFFF : 16'(p);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_data"}, 32'(rd_data), 0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 0);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_triggered"}, 32'(triggered), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Arms, feeds one sample per strobe interval and tracks status until the frame is full.
  task automatic run_capture(input vec_t v);
    int unsigned total;
    int unsigned last;
    total = v.exp_trig + DEPTH - v.pre;
    last  = total - 1;
    check("pre_arm_busy", 32'(busy), 0);
    trig_mode  = v.mode;
    pretrig    = AW'(v.pre);
    trig_level = DATA_W'(v.level);
    time_scale = 6'd0;
    sample_in  = DATA_W'(gen(v, 0));
    arm        = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    check("busy_after_arm", 32'(busy), 1);
    for (int unsigned k = 0; k < total; k++) begin
      sample_in = DATA_W'(gen(v, k));
      rd_en     = v.abuse && (k >= v.pre) && (k < v.exp_trig);
      arm       = v.abuse && (k > v.exp_trig) && (k < last);
      @(negedge clk);
      arm = 1'b0;
      repeat (8) @(negedge clk);
      check("full_before_strobe", {30'd0, full, rd_valid}, 0);
      @(negedge clk);
      check("status_after_strobe", {28'd0, full, triggered, busy, rd_valid},
            {28'd0, k == last, k >= v.exp_trig, k != last, 1'b0});
    end
    rd_en = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++)
      sb.push_back(scale(gen(v, v.exp_trig - v.pre + i)));
  endtask

  task automatic read_frame(input int unsigned n);
    logic [DATA_W-1:0] exp;
    for (int unsigned i = 0; i < n; i++) begin
      rd_en = 1'b1;
      @(negedge clk);
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard_empty: read %0d has no expected sample", i);
        exp = '0;
      end else begin
        exp = sb.pop_front();
      end
      check("rd_valid", 32'(rd_valid), 1);
      check("rd_data", 32'(rd_data), 32'(exp));
      check("empty_flag", 32'(empty), 32'(i == DEPTH - 1));
      check("full_flag", 32'(full), 32'(i != DEPTH - 1));
    end
    rd_en = 1'b0;
    @(negedge clk);
    check("rd_valid_after_reads", 32'(rd_valid), 0);
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; rd_en = 1'b0; sample_in = '0; trig_level = '0;
    time_scale = '0; trig_mode = '0; pretrig = '0;

    tbl[0]  = '{TRIG_RISE,  4, 500,   PAT_UP,    0,       1, 1'b0, 50};
    tbl[1]  = '{TRIG_FALL,  4, 300,   PAT_DN,    50,      1, 1'b0, 21};
    tbl[2]  = '{TRIG_LEVEL, 4, 400,   PAT_CONST, 40,      0, 1'b0, 4};
    tbl[3]  = '{TRIG_LEVEL, 3, 65535, PAT_UP,    6550,    1, 1'b0, 4};
    tbl[4]  = '{TRIG_LEVEL, 2, 65535, PAT_CONST, 'h2000,  0, 1'b0, 2};
    tbl[5]  = '{TRIG_RISE,  15, 500,  PAT_UP,    0,       1, 1'b0, 50};
    tbl[6]  = '{TRIG_FORCE, 15, 0,    PAT_UP,    100,     3, 1'b0, 15};
    tbl[7]  = '{TRIG_RISE,  0, 300,   PAT_NOTCH, 40,      5, 1'b0, 6};
    tbl[8]  = '{TRIG_RISE,  4, 500,   PAT_UP,    0,       1, 1'b1, 50};
    tbl[9]  = '{TRIG_FALL,  1, 200,   PAT_DN,    60,      1, 1'b0, 41};
    tbl[10] = '{TRIG_FORCE, 0, 0,     PAT_UP,    7,       1, 1'b0, 0};

    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      run_capture(tbl[i]);
      read_frame(DEPTH);
    end

    // Reads in IDLE must be ignored.
    rd_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_read_valid", {31'd0, rd_valid}, 0);
      check("idle_read_empty", {31'd0, empty}, 1);
    end
    rd_en = 1'b0;

    // Reset in the middle of POST.
    trig_mode = TRIG_FORCE; pretrig = '0; sample_in = 16'd5; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_post_triggered", 32'(triggered), 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_post");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_capture(tbl[0]);
    read_frame(DEPTH);

    // Reset part-way through readout.
    run_capture(tbl[1]);
    read_frame(5);
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_read");
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_capture(tbl[6]);
    read_frame(DEPTH);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
